morse_decoder: RTL

//  Receive end of the S..Z Morse link. Samples a serial on/off Morse line once per bit period,

---
 rtl/morse_decoder_pkg.sv | 20 ++
 rtl/morse_tick_gen.sv | 19 +
 rtl/morse_decoder.sv | 92 +++++++++
 3 files changed

// File: rtl/morse_decoder_pkg.sv
// morse_decoder_pkg: shared S..Z Morse letter table, default bit divider and decoder FSM states
package morse_decoder_pkg;
  localparam int DEFAULT_TICK_DIV = 25_000_000;
  typedef enum logic [2:0] {
    LETTER_S, LETTER_T, LETTER_U, LETTER_V, LETTER_W, LETTER_X, LETTER_Y, LETTER_Z
  } letter_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, DECODE} state_t;
  function automatic logic [15:0] letter_pattern(input letter_t code);
    case (code)
      LETTER_S: return 16'b1010100000000000;
      LETTER_T: return 16'b1110000000000000;
      LETTER_U: return 16'b1010111000000000;
      LETTER_V: return 16'b1010101110000000;
      LETTER_W: return 16'b1011101110000000;
      LETTER_X: return 16'b1110101011100000;
      LETTER_Y: return 16'b1110101110111000;
      default:  return 16'b1110111010100000;
    endcase
  endfunction
endpackage

// File: rtl/morse_tick_gen.sv
// morse_tick_gen: loadable bit-period down-counter, one-clock tick each time it reaches zero
module morse_tick_gen #(
  parameter int TICK_DIV = 4,
  parameter int W = $clog2(TICK_DIV)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic         tick
);
  logic [W-1:0] count;
  assign tick = enable && count == '0;
  always_ff @(posedge clock)
    if (!reset) count <= '0;
    else if (load) count <= load_value;
    else if (enable) count <= tick ? W'(TICK_DIV - 1) : count - W'(1);
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: samples a serial Morse line once per bit period and decodes letters S..Z
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int GAP_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       decode_error,
  output logic       busy
);
  localparam int W = $clog2(TICK_DIV);
  state_t state;
  letter_t code;
  logic sync_a, s_in, s_prev, overflow, tick, match, rise;
  logic [2:0] warm, zero_run, zero_nxt;
  logic [4:0] count, count_nxt;
  logic [15:0] pattern;
  // warm masks the false 0->1 seen while the reset-cleared synchroniser refills
  assign rise = s_in && !s_prev && warm[2];
  assign count_nxt = count + 5'd1;
  assign zero_nxt = s_in ? 3'd0 : zero_run + 3'd1;
  morse_tick_gen #(.TICK_DIV(TICK_DIV), .W(W)) u_tick (
    .clock(clock),
    .reset(reset),
    .load(state == IDLE && rise),
    .enable(state == CAPTURE),
    .load_value(W'(TICK_DIV / 2 - 1)),
    .tick(tick)
  );
  always_comb begin
    match = 1'b0;
    code = LETTER_S;
    for (int i = 0; i < 8; i++)
      if (pattern == letter_pattern(letter_t'(i))) begin
        match = 1'b1;
        code = letter_t'(i);
      end
  end
  always_ff @(posedge clock)
    if (!reset) {sync_a, s_in, s_prev, warm} <= '0;
    else {sync_a, s_in, s_prev, warm} <= {morse_in, sync_a, s_in, warm[1:0], 1'b1};
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      letter <= '0;
      letter_valid <= 1'b0;
      decode_error <= 1'b0;
      busy <= 1'b0;
      pattern <= '0;
      count <= '0;
      zero_run <= '0;
      overflow <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      decode_error <= 1'b0;
      case (state)
        IDLE:
          if (rise) begin
            pattern <= '0;
            count <= '0;
            zero_run <= '0;
            overflow <= 1'b0;
            busy <= 1'b1;
            state <= CAPTURE;
          end
        CAPTURE:
          if (tick) begin
            pattern[~count[3:0]] <= s_in;
            count <= count_nxt;
            zero_run <= zero_nxt;
            if (zero_nxt == 3'(GAP_TICKS)) state <= DECODE;
            else if (count_nxt == 5'd16) begin
              overflow <= 1'b1;
              state <= DECODE;
            end
          end
        default: begin
          if (match && !overflow) begin
            letter <= code;
            letter_valid <= 1'b1;
          end else decode_error <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule
